// File: rtl/kpyd_scan.sv
// 4x4 keypad scanner: drives one column at a time, debounces a press on the
// lowest active row, hands the key code over valid/ready and waits for release.
module kpyd_scan #(
  parameter int settle_p   = 16,
  parameter int debounce_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] rows_i,
  output logic [3:0] cols_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [3:0] key_o,
  output logic       held_o
);

  localparam int sw = $clog2(settle_p);
  localparam int dw = $clog2(debounce_p + 1);
  localparam logic [sw-1:0] settle_last = sw'(settle_p - 1);
  localparam logic [dw-1:0] deb_target  = dw'(debounce_p);

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    EMIT,
    RELEASE
  } state_e;

  state_e        state_q,   state_d;
  logic [1:0]    col_q,     col_d;
  logic [sw-1:0] settle_q,  settle_d;
  logic [dw-1:0] match_q,   match_d;
  logic [dw-1:0] release_q, release_d;
  logic [3:0]    cand_q,    cand_d;
  logic [3:0]    cols_q,    cols_d;
  logic          valid_q,   valid_d;
  logic [3:0]    key_q,     key_d;
  logic          held_q,    held_d;

  logic          sample;
  logic [1:0]    hit_row;
  logic          any_row;

  function automatic logic [1:0] lowest_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    col_d     = col_q;
    match_d   = match_q;
    release_d = release_q;
    cand_d    = cand_q;
    sample    = (settle_q == settle_last);
    any_row   = (rows_i != 4'b0000);
    hit_row   = lowest_row(rows_i);

    unique case (state_q)
      SCAN: begin
        if (sample) begin
          if (!any_row) begin
            col_d = col_q + 2'd1;
          end else begin
            cand_d  = {hit_row, col_q};
            match_d = dw'(1);
            state_d = (debounce_p == 1) ? EMIT : CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (sample) begin
          if (any_row && hit_row == cand_q[3:2]) begin
            if (match_q + dw'(1) == deb_target) begin
              state_d = EMIT;
              match_d = '0;
            end else begin
              match_d = match_q + dw'(1);
            end
          end else begin
            state_d = SCAN;
            match_d = '0;
            col_d   = col_q + 2'd1;
          end
        end
      end
      EMIT: begin
        if (ready_i) begin
          state_d   = RELEASE;
          release_d = '0;
        end
      end
      RELEASE: begin
        if (sample) begin
          if (any_row) begin
            release_d = '0;
          end else if (release_q + dw'(1) == deb_target) begin
            state_d   = SCAN;
            release_d = '0;
            col_d     = col_q + 2'd1;
          end else begin
            release_d = release_q + dw'(1);
          end
        end
      end
      default: state_d = SCAN;
    endcase

    // Column changes only on a sample edge, so this restart also realises the wrap.
    settle_d = (sample || col_d != col_q) ? '0 : settle_q + sw'(1);

    key_d   = (state_d == EMIT && state_q != EMIT) ? cand_d : key_q;
    valid_d = (state_d == EMIT);
    held_d  = (state_d == EMIT) || (state_d == RELEASE);
    cols_d  = ~(4'b0001 << col_d);
  end

  // NOTE: reset is synchronous, and all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      settle_q  <= '0;
      match_q   <= '0;
      release_q <= '0;
      cand_q    <= 4'd0;
      cols_q    <= 4'b1110;
      valid_q   <= 1'b0;
      key_q     <= 4'd0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      release_q <= release_d;
      cand_q    <= cand_d;
      cols_q    <= cols_d;
      valid_q   <= valid_d;
      key_q     <= key_d;
      held_q    <= held_d;
    end
  end

  assign cols_o  = cols_q;
  assign valid_o = valid_q;
  assign key_o   = key_q;
  assign held_o  = held_q;

endmodule

// File: tb/tb_kpyd_scan.sv
// Self-checking bench for kpyd_scan: a virtual 4x4 keypad answers the driven
// column, and a press/accept/release model predicts all outputs every cycle.
module tb_kpyd_scan;

  localparam int S = 16;
  localparam int D = 4;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] rows_i;
  logic [3:0] cols_o;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] key_o;
  logic       held_o;

  always #5 clk_i = ~clk_i;

  kpyd_scan #(.settle_p(S), .debounce_p(D)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .rows_i  (rows_i),
    .cols_o  (cols_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .key_o   (key_o),
    .held_o  (held_o)
  );

  int    n_run  = 0;
  int    n_fail = 0;
  string phase  = "init";
  bit    pad [4][4];   // pad[row][col] = 1 while that key is physically down

  // Reference model: edges since reset, driven column, candidate key (-1 none).
  int m_edges, m_col, m_cand, m_hits, m_quiet, m_key;
  bit m_valid, m_held;

  int   xfers, rises;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      if (n_fail <= 20) $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pad_rows(input logic [3:0] cols);
    logic [3:0] r;
    logic [3:0] sel;
    r = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      sel = 4'b0001 << c;
      if (cols === ~sel) begin
        for (int row = 0; row < 4; row++) r[row] = pad[row][c];
      end
    end
    return r;
  endfunction

  function automatic int lowest(input logic [3:0] r);
    int res;
    res = -1;
    for (int i = 3; i >= 0; i--) if (r[i]) res = i;
    return res;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [3:0] sel;
    sel = 4'b0001 << m_col;
    return {~sel, m_valid, 4'(m_key), m_held};
  endfunction

  task automatic accept_key();
    m_valid = 1'b1;
    m_held  = 1'b1;
    m_key   = m_cand;
    m_cand  = -1;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rdy, input logic rst);
    bit sample;
    if (rst) begin
      m_edges = 0; m_col = 0; m_cand = -1; m_hits = 0; m_quiet = 0;
      m_key = 0; m_valid = 1'b0; m_held = 1'b0;
    end else begin
      m_edges++;
      sample = (m_edges % S) == 0;
      if (m_valid) begin
        if (rdy) begin
          m_valid = 1'b0;
          m_quiet = 0;
        end
      end else if (m_held) begin
        if (sample) begin
          if (r == 4'b0000) m_quiet++;
          else m_quiet = 0;
          if (m_quiet == D) begin
            m_held  = 1'b0;
            m_quiet = 0;
            m_col   = (m_col + 1) % 4;
          end
        end
      end else if (m_cand >= 0) begin
        if (sample) begin
          if (r != 4'b0000 && lowest(r) * 4 + m_col == m_cand) begin
            m_hits++;
            if (m_hits == D) accept_key();
          end else begin
            m_cand = -1;
            m_col  = (m_col + 1) % 4;
          end
        end
      end else if (sample) begin
        if (r == 4'b0000) begin
          m_col = (m_col + 1) % 4;
        end else begin
          m_cand = lowest(r) * 4 + m_col;
          m_hits = 1;
          if (m_hits == D) accept_key();
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0] r;
    logic       rdy, rst;
    rows_i = pad_rows(cols_o);
    r   = rows_i;
    rdy = ready_i;
    rst = reset_i;
    if (!rst && valid_o === 1'b1 && rdy) xfers++;
    @(posedge clk_i);
    model_edge(r, rdy, rst);
    #1;
    if (valid_o === 1'b1 && prev_valid !== 1'b1) rises++;
    prev_valid = valid_o;
    check(phase, {22'd0, cols_o, valid_o, key_o, held_o}, {22'd0, exp_vec()});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_pad();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pad[r][c] = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    xfers = 0;
    rises = 0;
  endtask

  initial begin
    reset_i = 1'b1;
    ready_i = 1'b0;
    rows_i  = 4'b0000;
    clear_pad();

    phase = "reset";
    do_reset();
    check("reset_state", {22'd0, cols_o, valid_o, key_o, held_o}, {22'd0, 10'b1110_0_0000_0});

    phase = "idle";
    run(128);
    check("idle_no_valid", 32'(rises), 32'd0);

    phase = "press_r2c0";
    do_reset();
    pad[2][0] = 1'b1;
    run(63);
    check("press_not_yet", {31'd0, valid_o}, 32'd0);
    run(1);
    check("press_valid", {31'd0, valid_o}, 32'd1);
    check("press_key", {28'd0, key_o}, 32'd8);
    check("press_held", {31'd0, held_o}, 32'd1);

    phase = "backpressure";
    run(50);
    check("bp_key", {28'd0, key_o}, 32'd8);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("bp_one_xfer", 32'(xfers), 32'd1);

    phase = "hold";
    ready_i = 1'b1;
    run(500);
    check("hold_no_second_valid", 32'(rises), 32'd1);
    check("hold_xfers", 32'(xfers), 32'd1);
    check("hold_held", {31'd0, held_o}, 32'd1);
    pad[2][0] = 1'b0;
    phase = "release";
    run(80);
    check("release_held_low", {31'd0, held_o}, 32'd0);
    ready_i = 1'b0;

    phase = "bounce";
    do_reset();
    run(40);
    pad[1][2] = 1'b1;
    run(30);
    pad[1][2] = 1'b0;
    run(20);
    check("bounce_col3", {28'd0, cols_o}, 32'b0111);
    check("bounce_no_valid", 32'(rises), 32'd0);

    phase = "multi_row";
    do_reset();
    pad[1][3] = 1'b1;
    pad[3][3] = 1'b1;
    run(112);
    check("multi_valid", {31'd0, valid_o}, 32'd1);
    check("multi_key", {28'd0, key_o}, 32'd7);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    clear_pad();
    run(80);

    phase = "reset_confirm";
    do_reset();
    pad[0][0] = 1'b1;
    run(20);
    reset_i = 1'b1;
    pad[0][0] = 1'b0;
    step();
    reset_i = 1'b0;
    check("rc_cols", {28'd0, cols_o}, 32'b1110);
    check("rc_valid", {31'd0, valid_o}, 32'd0);
    rises = 0;
    run(100);
    check("rc_abandoned", 32'(rises), 32'd0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 299));
      if (sel == 0) begin
        reset_i = 1'b1;
      end else if (sel < 4) begin
        clear_pad();
      end else if (sel < 7) begin
        pad[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      end
      ready_i = 1'($urandom_range(0, 1));
      step();
      reset_i = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/kpyd_scan.md
KPYD_SCAN -- requirements
Module: kpyd_scan

Interface
REQ-001 Parameter: settle_p, 16, clock cycles each column is driven before rows are sampled (>=2).
REQ-002 Parameter: debounce_p, 4, consecutive identical samples required to accept a press or a release (>=1).
REQ-003 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset_i  input  1  synchronous, active-high reset.
REQ-005 Port: rows_i  input  4  keypad rows, already synchronized upstream, active-high (1 = pressed).
REQ-006 Port: cols_o  output  4  column drive, active-low one-hot (cols_o[c]=0 selects column c).
REQ-007 Port: valid_o  output  1  key_o holds an accepted key code.
REQ-008 Port: ready_i  input  1  consumer accepts key_o when valid_o & ready_i.
REQ-009 Port: key_o  output  4  key code = row*4 + col.
REQ-010 Port: held_o  output  1  an accepted key has not yet been released.

Function
REQ-011 The block SHALL have four states: SCAN, CONFIRM, EMIT, RELEASE.
REQ-012 Settle counter: counts 0..settle_p-1 and wraps; a sample is taken on the edge where count==settle_p-1; the counter restarts at 0 whenever the column changes.
REQ-013 Decoded row: the lowest set bit index of rows_i; all other set rows are ignored.
REQ-014 SCAN, sample with rows_i==0: advance to the next column (3 wraps to 0) on the same edge.
REQ-015 SCAN, sample with rows_i!=0: latch candidate {row, col}, set match count to 1, keep the column, go to CONFIRM; if debounce_p==1, go directly to EMIT.
REQ-016 CONFIRM, sample with the same decoded row: increment the match count; on reaching debounce_p, go to EMIT.
REQ-017 CONFIRM, sample with a different row or rows_i==0: discard the candidate, advance the column, return to SCAN.
REQ-018 EMIT: valid_o=1 and key_o=candidate; key_o SHALL remain stable while valid_o=1; the column stays fixed; rows_i is ignored.
REQ-019 EMIT with valid_o & ready_i on an edge: valid_o falls on that edge, release count clears, go to RELEASE.
REQ-020 RELEASE: the column stays fixed; a sample with rows_i==0 increments the release count; any nonzero sample clears it.
REQ-021 RELEASE, release count reaching debounce_p: advance the column and go to SCAN.
REQ-022 held_o=1 in EMIT and RELEASE, 0 otherwise.
REQ-023 No key code SHALL be emitted twice for one continuous press.
REQ-024 ready_i SHALL be ignored when valid_o=0.
REQ-025 Counter widths: $clog2(settle_p) and $clog2(debounce_p+1); counters SHALL never wrap past their terminal values.
REQ-026 Outputs SHALL be registered; there is no combinational path from rows_i or ready_i to any output.

Reset
REQ-027 While reset_i=1 at an edge, the block SHALL set: state=SCAN, cols_o=4'b1110, valid_o=0, key_o=0, held_o=0, all counters=0.
REQ-028 Reset asserted mid-press or mid-handshake SHALL abandon the pending key; no valid_o is produced for it after reset.
REQ-029 After reset deasserts, the first sample SHALL occur settle_p edges later, on column 0.

Verification (settle_p=16, debounce_p=4)
REQ-030 Idle: rows_i=0 for 128 cycles -> cols_o cycles 1110,1101,1011,0111,1110 with a 16-cycle period per column; valid_o stays 0.
REQ-031 Column 0, row 2 pressed from reset (rows_i=4'b0100 while cols_o=1110) -> valid_o rises after edge 64, key_o=8, held_o=1.
REQ-032 Bounce: row 1 on column 2 is present for 2 samples, then absent -> no valid_o; scanning resumes at column 3.
REQ-033 Backpressure: ready_i=0 for 50 cycles while valid_o=1 -> key_o is unchanged throughout; one ready_i pulse gives exactly one transfer.
REQ-034 Hold and release: the key is held 500 cycles after the transfer -> no second valid_o; after release, held_o falls after 4 zero samples (64 cycles).
REQ-035 Rows 4'b1010 together on column 3 -> key_o=7 (row 1); reset_i pulsed during CONFIRM -> cols_o=1110 and valid_o=0 on the next edge.
